// File: rtl/sreg_file_pkg.sv
// Shared types and helpers for the scalar register file family.
package sreg_file_pkg;

  // Write-staging FSM states (2-bit encoding).
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFill   = 2'd1,
    StCommit = 2'd2
  } wr_state_e;

  // Ceiling log2 for parameter derivation; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sreg_wr_stager.sv
// Write staging: collects BUS_W-wide beats into a full register word and
// presents it for a single-cycle atomic commit.
module sreg_wr_stager
  import sreg_file_pkg::*;
#(
  parameter int unsigned REG_W = 16,
  parameter int unsigned BUS_W = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             WrStart,
  input  logic [AW-1:0]    WrAddr,
  input  logic             WrValid,
  input  logic [BUS_W-1:0] WrData,
  output logic             WrBusy,
  output logic             commit,
  output logic [AW-1:0]    commit_addr,
  output logic [REG_W-1:0] commit_data
);

  localparam int unsigned LANES = REG_W / BUS_W;
  // Lane counter needs at least one bit even when LANES == 1.
  localparam int unsigned LW    = (LANES > 1) ? clog2(LANES) : 1;

  wr_state_e         state_q;
  logic [LW-1:0]     lane_q;
  logic [REG_W-1:0]  stage_q;
  logic [AW-1:0]     addr_q;
  logic              busy_q;
  logic              done_q;

  // FSM, lane counter, staging buffer and registered status outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StIdle;
      lane_q  <= '0;
      stage_q <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Beats arriving with (or without) a start in IDLE are dropped.
          if (WrStart) begin
            addr_q  <= WrAddr;
            lane_q  <= '0;
            state_q <= StFill;
            busy_q  <= 1'b1;
          end
        end
        StFill: begin
          if (WrValid) begin
            for (int l = 0; l < int'(LANES); l++) begin
              if (lane_q == LW'(l)) begin
                stage_q[l*BUS_W +: BUS_W] <= WrData;
              end
            end
            if (lane_q == LW'(LANES - 1)) begin
              lane_q  <= '0;
              state_q <= StCommit;
              done_q  <= 1'b1;
            end else begin
              lane_q <= lane_q + LW'(1);
            end
          end
        end
        StCommit: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign WrBusy      = busy_q;
  // done_q is high exactly while in COMMIT, so it doubles as the commit strobe.
  assign commit      = done_q;
  assign commit_addr = addr_q;
  assign commit_data = stage_q;

endmodule

// File: rtl/sreg_file.sv
// Parametrised scalar register file: staged narrow-bus writes with atomic
// commit, two independent registered read ports with write-through bypass.
module sreg_file
  import sreg_file_pkg::*;
#(
  parameter int unsigned NREG  = 8,
  parameter int unsigned REG_W = 16,
  parameter int unsigned BUS_W = 8,
  parameter int unsigned AW    = clog2(NREG)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             WrStart,
  input  logic [AW-1:0]    WrAddr,
  input  logic             WrValid,
  input  logic [BUS_W-1:0] WrData,
  output logic             WrBusy,
  output logic             WrDone,
  input  logic             RdEnA,
  input  logic [AW-1:0]    RdAddrA,
  output logic [REG_W-1:0] RdDataA,
  input  logic             RdEnB,
  input  logic [AW-1:0]    RdAddrB,
  output logic [REG_W-1:0] RdDataB
);

  logic             commit;
  logic [AW-1:0]    commit_addr;
  logic [REG_W-1:0] commit_data;

  logic [REG_W-1:0] regs_q [NREG];
  logic [REG_W-1:0] rd_a_q;
  logic [REG_W-1:0] rd_b_q;

  sreg_wr_stager #(
    .REG_W (REG_W),
    .BUS_W (BUS_W),
    .AW    (AW)
  ) u_stager (
    .Clk         (Clk),
    .Rst         (Rst),
    .WrStart     (WrStart),
    .WrAddr      (WrAddr),
    .WrValid     (WrValid),
    .WrData      (WrData),
    .WrBusy      (WrBusy),
    .commit      (commit),
    .commit_addr (commit_addr),
    .commit_data (commit_data)
  );

  // Register array: whole-word update only on the commit edge.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit) begin
      regs_q[commit_addr] <= commit_data;
    end
  end

  // Read port A with bypass of the word being committed this cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rd_a_q <= '0;
    end else if (RdEnA) begin
      rd_a_q <= (commit && (RdAddrA == commit_addr)) ? commit_data : regs_q[RdAddrA];
    end
  end

  // Read port B, identical to port A.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rd_b_q <= '0;
    end else if (RdEnB) begin
      rd_b_q <= (commit && (RdAddrB == commit_addr)) ? commit_data : regs_q[RdAddrB];
    end
  end

  assign WrDone  = commit;
  assign RdDataA = rd_a_q;
  assign RdDataB = rd_b_q;

endmodule
